// File: rtl/temporizador_antirrebote.sv
// Retriggerable debounce window timer: a rising edge on actCuenta opens a
// T_MS x CICLOS_MS cycle window; expiry yields a one-cycle t300ms pulse.
module temporizador_antirrebote #(
  parameter int CICLOS_MS = 50000,
  parameter int T_MS      = 300,
  parameter int PRE_W     = 16,
  parameter int MS_W      = 9
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       actCuenta,
  input  logic       cancelar,
  output logic       t300ms,
  output logic       ocupado,
  output logic [7:0] reinicios
);

  // One-hot so each output is a direct copy of a state flop (glitch-free).
  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    CONTANDO = 3'b010,
    FIN      = 3'b100
  } state_t;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CICLOS_MS - 1);
  localparam logic [MS_W-1:0]  MS_MAX  = MS_W'(T_MS - 1);

  state_t            state;
  state_t            state_nx;
  logic              act_q;
  logic              start;
  logic              tick;
  logic              expira;
  logic [PRE_W-1:0]  pre_cnt;
  logic [MS_W-1:0]   ms_cnt;

  assign start  = actCuenta & ~act_q;
  assign tick   = (state == CONTANDO) && (pre_cnt == PRE_MAX);
  assign expira = tick && (ms_cnt == MS_MAX);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) act_q <= 1'b0;
    else        act_q <= actCuenta;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    if (cancelar) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:     if (start) state_nx = CONTANDO;
        CONTANDO: begin
          if (start)       state_nx = CONTANDO;
          else if (expira) state_nx = FIN;
        end
        FIN:      state_nx = start ? CONTANDO : IDLE;
        default:  state_nx = IDLE;
      endcase
    end
  end

  // Counters only run while staying in CONTANDO without a retrigger; any
  // other transition (start, expiry, abort, idle) leaves them at zero.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else if (state_nx != CONTANDO || start) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      ms_cnt  <= ms_cnt + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // A start inside a running window is a retrigger; elsewhere it is fresh.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      reinicios <= 8'd0;
    end else if (!cancelar && start) begin
      if (state == CONTANDO) begin
        if (reinicios != 8'hFF) reinicios <= reinicios + 8'd1;
      end else begin
        reinicios <= 8'd0;
      end
    end
  end

  always_comb begin
    ocupado = state[1];
    t300ms  = state[2];
  end

endmodule

// File: tb/tb_temporizador_antirrebote.sv
// Directed bench for temporizador_antirrebote with CICLOS_MS=4, T_MS=3 (N=12).
// Edge numbers count rising clock edges since the last reset release.
module tb_temporizador_antirrebote;

  logic       clk;
  logic       rst_n;
  logic       act;
  logic       cancel;
  logic       t300ms;
  logic       ocupado;
  logic [7:0] reinicios;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_cnt     = 0;
  int base         = 0;

  temporizador_antirrebote #(
    .CICLOS_MS(4),
    .T_MS     (3),
    .PRE_W    (4),
    .MS_W     (4)
  ) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .actCuenta(act),
    .cancelar (cancel),
    .t300ms   (t300ms),
    .ocupado  (ocupado),
    .reinicios(reinicios)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Advance to 1 time unit after relative edge e.
  task automatic go_to(input int e);
    while (edge_cnt - base < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    act    = 1'b0;
    cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = edge_cnt;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    act    = 1'b1;
    cancel = 1'b0;
    #2;
    tests_run++;
    if (ocupado !== 1'b0) begin
      $display("FAIL reset ocupado: got %b expected 0", ocupado); tests_failed++;
    end
    tests_run++;
    if (t300ms !== 1'b0) begin
      $display("FAIL reset t300ms: got %b expected 0", t300ms); tests_failed++;
    end
    tests_run++;
    if (reinicios !== 8'd0) begin
      $display("FAIL reset reinicios: got %0d expected 0", reinicios); tests_failed++;
    end
  endtask

  task automatic test_basic();
    logic exp_t, exp_o;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      go_to(e);
      exp_t = (e == 17);
      exp_o = (e >= 5 && e < 17);
      tests_run++;
      if (t300ms !== exp_t) begin
        $display("FAIL basic t300ms edge %0d: got %b expected %b", e, t300ms, exp_t); tests_failed++;
      end
      tests_run++;
      if (ocupado !== exp_o) begin
        $display("FAIL basic ocupado edge %0d: got %b expected %b", e, ocupado, exp_o); tests_failed++;
      end
      act = (e + 1 >= 5);
    end
    tests_run++;
    if (reinicios !== 8'd0) begin
      $display("FAIL basic reinicios: got %0d expected 0", reinicios); tests_failed++;
    end
  endtask

  task automatic test_bounce();
    logic exp_t, exp_o;
    int n;
    do_reset();
    for (int e = 1; e <= 28; e++) begin
      go_to(e);
      exp_t = (e == 25);
      exp_o = (e >= 5 && e < 25);
      tests_run++;
      if (t300ms !== exp_t) begin
        $display("FAIL bounce t300ms edge %0d: got %b expected %b", e, t300ms, exp_t); tests_failed++;
      end
      tests_run++;
      if (ocupado !== exp_o) begin
        $display("FAIL bounce ocupado edge %0d: got %b expected %b", e, ocupado, exp_o); tests_failed++;
      end
      n   = e + 1;
      act = (n == 5 || n == 6 || n == 9 || n == 10 || n >= 13);
    end
    tests_run++;
    if (reinicios !== 8'd2) begin
      $display("FAIL bounce reinicios: got %0d expected 2", reinicios); tests_failed++;
    end
  endtask

  task automatic test_retrigger_at_expiry();
    logic exp_t, exp_o;
    int n;
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      go_to(e);
      exp_t = (e == 29);
      exp_o = (e >= 5 && e < 29);
      tests_run++;
      if (t300ms !== exp_t) begin
        $display("FAIL expiry_retrig t300ms edge %0d: got %b expected %b", e, t300ms, exp_t); tests_failed++;
      end
      tests_run++;
      if (ocupado !== exp_o) begin
        $display("FAIL expiry_retrig ocupado edge %0d: got %b expected %b", e, ocupado, exp_o); tests_failed++;
      end
      n   = e + 1;
      act = ((n >= 5 && n <= 10) || n >= 17);
    end
    tests_run++;
    if (reinicios !== 8'd1) begin
      $display("FAIL expiry_retrig reinicios: got %0d expected 1", reinicios); tests_failed++;
    end
  endtask

  task automatic test_abort();
    logic exp_t, exp_o;
    int n;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      go_to(e);
      exp_t = (e == 32);
      exp_o = (e >= 5 && e < 10) || (e >= 20 && e < 32);
      tests_run++;
      if (t300ms !== exp_t) begin
        $display("FAIL abort t300ms edge %0d: got %b expected %b", e, t300ms, exp_t); tests_failed++;
      end
      tests_run++;
      if (ocupado !== exp_o) begin
        $display("FAIL abort ocupado edge %0d: got %b expected %b", e, ocupado, exp_o); tests_failed++;
      end
      if (e == 15) begin
        tests_run++;
        if (reinicios !== 8'd1) begin
          $display("FAIL abort reinicios_held: got %0d expected 1", reinicios); tests_failed++;
        end
      end
      n      = e + 1;
      act    = (n == 5 || n == 6 || n == 8 || n == 9 || (n >= 20 && n <= 22));
      cancel = (n == 10);
    end
    tests_run++;
    if (reinicios !== 8'd0) begin
      $display("FAIL abort reinicios_fresh: got %0d expected 0", reinicios); tests_failed++;
    end
  endtask

  task automatic test_reset_mid_window();
    logic exp_t, exp_o;
    do_reset();
    // Start at 5, retrigger at 7, held high afterwards.
    for (int e = 1; e <= 9; e++) begin
      go_to(e);
      act = (e + 1 == 5 || e + 1 >= 7);
    end
    tests_run++;
    if (ocupado !== 1'b1 || reinicios !== 8'd1) begin
      $display("FAIL midreset pre ocupado/reinicios: got %b/%0d expected 1/1", ocupado, reinicios); tests_failed++;
    end
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (ocupado !== 1'b0 || t300ms !== 1'b0 || reinicios !== 8'd0) begin
      $display("FAIL midreset async: got ocupado=%b t300ms=%b reinicios=%0d expected 0/0/0",
               ocupado, t300ms, reinicios); tests_failed++;
    end
    go_to(11);
    rst_n = 1'b1;
    // act still high: edge 12 sees a rising edge and starts a new window.
    for (int e = 12; e <= 26; e++) begin
      go_to(e);
      exp_t = (e == 24);
      exp_o = (e >= 12 && e < 24);
      tests_run++;
      if (t300ms !== exp_t) begin
        $display("FAIL midreset_high t300ms edge %0d: got %b expected %b", e, t300ms, exp_t); tests_failed++;
      end
      tests_run++;
      if (ocupado !== exp_o) begin
        $display("FAIL midreset_high ocupado edge %0d: got %b expected %b", e, ocupado, exp_o); tests_failed++;
      end
    end
    // Same interruption with act low at release: block stays idle.
    go_to(30);
    rst_n = 1'b0;
    act   = 1'b0;
    go_to(32);
    rst_n = 1'b1;
    for (int e = 33; e <= 50; e++) begin
      go_to(e);
      tests_run++;
      if (ocupado !== 1'b0 || t300ms !== 1'b0) begin
        $display("FAIL midreset_low edge %0d: got ocupado=%b t300ms=%b expected 0/0",
                 e, ocupado, t300ms); tests_failed++;
      end
    end
  endtask

  task automatic test_saturation_back_to_back();
    logic exp_t, exp_o;
    int n;
    do_reset();
    // Rises at every odd edge 5..605: start plus 300 retriggers.
    for (int e = 1; e <= 632; e++) begin
      go_to(e);
      if (e == 513) begin
        tests_run++;
        if (reinicios !== 8'd254) begin
          $display("FAIL sat reinicios_254: got %0d expected 254", reinicios); tests_failed++;
        end
      end
      if (e == 515 || e == 617) begin
        tests_run++;
        if (reinicios !== 8'd255) begin
          $display("FAIL sat reinicios_255 edge %0d: got %0d expected 255", e, reinicios); tests_failed++;
        end
      end
      if (e == 618) begin
        tests_run++;
        if (reinicios !== 8'd0) begin
          $display("FAIL b2b reinicios_clear: got %0d expected 0", reinicios); tests_failed++;
        end
      end
      if (e >= 600) begin
        exp_t = (e == 617 || e == 630);
        exp_o = (e < 617) || (e >= 618 && e < 630);
        tests_run++;
        if (t300ms !== exp_t) begin
          $display("FAIL b2b t300ms edge %0d: got %b expected %b", e, t300ms, exp_t); tests_failed++;
        end
        tests_run++;
        if (ocupado !== exp_o) begin
          $display("FAIL b2b ocupado edge %0d: got %b expected %b", e, ocupado, exp_o); tests_failed++;
        end
      end
      n   = e + 1;
      act = (n >= 5 && n <= 605 && (n % 2) == 1) || n == 618;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_retrigger_at_expiry();
    test_abort();
    test_reset_mid_window();
    test_saturation_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
